// File: rtl/ddr_pixel_fetch_pkg.sv
// Shared video/DDR definitions: fetch FSM states,
// default frame geometry and the frame address stepper.
package ddr_pixel_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } fetch_state_e;

  localparam logic [23:0] DEF_BASE_ADDRESS = 24'h000000;
  localparam int          DEF_FRAME_WORDS  = 307200;
  localparam int          DEF_FIFO_DEPTH   = 16;

  function automatic logic [23:0] next_addr(
    input logic [23:0] addr,
    input logic [23:0] base,
    input logic [23:0] last
  );
    return (addr == last) ? base : addr + 24'd1;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Show-ahead pixel FIFO clocked on the falling edge;
// head word reads as zero while empty.
module pixel_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [15:0]              din,
  output logic [15:0]              dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     valid
);

  localparam int AW = $clog2(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign valid   = (count != '0);
  assign do_push = push && (count != (AW+1)'(DEPTH));
  assign do_pop  = pop && valid;
  assign dout    = valid ? mem[rd_ptr] : 16'h0000;

  always_ff @(negedge clk) begin
    if (do_push && !flush)
      mem[wr_ptr] <= din;
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ddr_pixel_fetch.sv
// Streams a frame from DDR into the pixel FIFO using a
// four-phase read handshake, one request in flight at a time.
module ddr_pixel_fetch
  import ddr_pixel_fetch_pkg::*;
#(
  parameter logic [23:0] BASE_ADDRESS = DEF_BASE_ADDRESS,
  parameter int          FRAME_WORDS  = DEF_FRAME_WORDS,
  parameter int          FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic        clk133_p,
  input  logic        rst,
  input  logic        frameStart,
  output logic        read,
  output logic [23:0] readAddress,
  input  logic        readAcknowledge,
  input  logic [15:0] readData,
  input  logic        pixelRead,
  output logic        pixelValid,
  output logic [15:0] pixelData,
  output logic        underflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [23:0] LAST_ADDRESS =
    BASE_ADDRESS + 24'(FRAME_WORDS - 1);

  fetch_state_e  state;
  logic          pending;
  logic [CW-1:0] count;
  logic          has_room;
  logic          push;
  logic          flush;

  assign has_room = (count < CW'(FIFO_DEPTH));
  assign push     = (state == REQ) && readAcknowledge;
  assign flush    = (state == IDLE) && pending;

  // One outstanding read plus gating on free space means
  // a push can never land on a full FIFO.
  always_ff @(negedge clk133_p or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      read        <= 1'b0;
      readAddress <= BASE_ADDRESS;
      pending     <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (frameStart)
        pending <= 1'b1;
      else if (flush)
        pending <= 1'b0;

      if (flush)
        underflow <= 1'b0;
      else if (pixelRead && !pixelValid)
        underflow <= 1'b1;

      unique case (state)
        IDLE: begin
          if (flush) begin
            readAddress <= BASE_ADDRESS;
          end else if (!frameStart && has_room) begin
            state <= REQ;
            read  <= 1'b1;
          end
        end
        REQ: begin
          if (readAcknowledge) begin
            read        <= 1'b0;
            readAddress <= next_addr(readAddress,
                                     BASE_ADDRESS,
                                     LAST_ADDRESS);
            state       <= RELEASE;
          end
        end
        RELEASE: begin
          if (!readAcknowledge)
            state <= IDLE;
        end
        default: begin
          state <= IDLE;
          read  <= 1'b0;
        end
      endcase
    end
  end

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk133_p),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pixelRead),
    .din   (readData),
    .dout  (pixelData),
    .count (count),
    .valid (pixelValid)
  );

endmodule

// File: tb/tb_ddr_pixel_fetch.sv
// Bench for ddr_pixel_fetch: DDR controller model feeding
// an expected-word queue that pixel pops are scored against.
module tb_ddr_pixel_fetch;

  localparam logic [23:0] BASE  = 24'h000000;
  localparam int          FW    = 20;
  localparam int          DEPTH = 16;
  localparam logic [23:0] LAST  = BASE + 24'(FW - 1);

  logic        clk133_p = 1'b0;
  logic        rst = 1'b1;
  logic        frameStart = 1'b0;
  logic        readAcknowledge = 1'b0;
  logic [15:0] readData = 16'h0000;
  logic        pixelRead = 1'b0;
  logic        read;
  logic [23:0] readAddress;
  logic        pixelValid;
  logic [15:0] pixelData;
  logic        underflow;

  int checks = 0;
  int passes = 0;

  logic [15:0] exp_q[$];
  logic [23:0] exp_addr = BASE;
  logic [23:0] req_addr = BASE;
  logic [23:0] last_ack_addr = BASE;
  int ack_count = 0;
  int wait_cnt = 0;
  int hold_cnt = 0;
  int extra_hold = 0;
  bit wrap_armed = 1'b0;
  bit wrap_seen = 1'b0;

  always #5 clk133_p = ~clk133_p;

  ddr_pixel_fetch #(
    .BASE_ADDRESS (BASE),
    .FRAME_WORDS  (FW),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk133_p        (clk133_p),
    .rst             (rst),
    .frameStart      (frameStart),
    .read            (read),
    .readAddress     (readAddress),
    .readAcknowledge (readAcknowledge),
    .readData        (readData),
    .pixelRead       (pixelRead),
    .pixelValid      (pixelValid),
    .pixelData       (pixelData),
    .underflow       (underflow)
  );

  // Controller: ack on the 6th rising edge that sees read,
  // data = address, ack held extra_hold edges after read drops.
  always @(posedge clk133_p) begin
    if (rst) begin
      readAcknowledge = 1'b0;
      wait_cnt = 0;
      hold_cnt = 0;
    end else if (readAcknowledge) begin
      if (!read) begin
        if (hold_cnt == 0) readAcknowledge = 1'b0;
        else hold_cnt--;
      end
    end else if (read) begin
      if (wait_cnt == 0) begin
        req_addr = readAddress;
      end else begin
        checks++;
        if (readAddress !== req_addr)
          $display("FAIL addr_hold: got %h want %h",
                   readAddress, req_addr);
        else passes++;
      end
      wait_cnt++;
      if (wait_cnt == 6) begin
        checks++;
        if (readAddress !== exp_addr)
          $display("FAIL req_addr: got %h want %h",
                   readAddress, exp_addr);
        else passes++;
        readData = readAddress[15:0];
        readAcknowledge = 1'b1;
        wait_cnt = 0;
        hold_cnt = extra_hold;
        ack_count++;
        last_ack_addr = readAddress;
        exp_q.push_back(exp_addr[15:0]);
        if (wrap_armed && exp_addr == BASE) wrap_seen = 1'b1;
        if (exp_addr == LAST) wrap_armed = 1'b1;
        exp_addr = (exp_addr == LAST) ? BASE : exp_addr + 24'd1;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic tick();
    @(posedge clk133_p);
    #1;
  endtask

  task automatic reset_model();
    exp_q.delete();
    exp_addr = BASE;
    wrap_armed = 1'b0;
    wrap_seen = 1'b0;
  endtask

  task automatic pop_stream(input int n);
    int got = 0;
    int cyc = 0;
    logic [15:0] exp;
    while (got < n && cyc < 1500) begin
      tick();
      cyc++;
      if (pixelValid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL pop_data: got %h want none", pixelData);
        end else begin
          exp = exp_q.pop_front();
          if (pixelData !== exp)
            $display("FAIL pop_data: got %h want %h",
                     pixelData, exp);
          else passes++;
        end
        pixelRead = 1'b1;
        got++;
      end else begin
        pixelRead = 1'b0;
      end
    end
    if (got < n) begin
      checks++;
      $display("FAIL pop_timeout: got %0d want %0d", got, n);
    end
    @(negedge clk133_p);
    #1;
    pixelRead = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    reset_model();
    tick();
    tick();
    checks++;
    if (read !== 1'b0)
      $display("FAIL rst_read: got %b want 0", read);
    else passes++;
    checks++;
    if (readAddress !== BASE)
      $display("FAIL rst_addr: got %h want %h", readAddress, BASE);
    else passes++;
    checks++;
    if (pixelValid !== 1'b0)
      $display("FAIL rst_valid: got %b want 0", pixelValid);
    else passes++;
    checks++;
    if (pixelData !== 16'h0000)
      $display("FAIL rst_data: got %h want 0000", pixelData);
    else passes++;
    checks++;
    if (underflow !== 1'b0)
      $display("FAIL rst_uflow: got %b want 0", underflow);
    else passes++;
  endtask

  task automatic test_fill();
    int cyc = 0;
    bit bad = 1'b0;
    rst = 1'b0;
    while (!readAcknowledge && cyc < 50) begin
      tick();
      cyc++;
    end
    checks++;
    if (readAcknowledge !== 1'b1)
      $display("FAIL first_ack: got %b want 1", readAcknowledge);
    else passes++;
    checks++;
    if (pixelValid !== 1'b0)
      $display("FAIL pre_push_valid: got %b want 0", pixelValid);
    else passes++;
    tick();
    checks++;
    if (pixelValid !== 1'b1)
      $display("FAIL push_valid: got %b want 1", pixelValid);
    else passes++;
    checks++;
    if (pixelData !== 16'h0000)
      $display("FAIL push_head: got %h want 0000", pixelData);
    else passes++;
    cyc = 0;
    while (ack_count < DEPTH && cyc < 400) begin
      tick();
      cyc++;
    end
    checks++;
    if (ack_count != DEPTH)
      $display("FAIL fill_acks: got %0d want %0d", ack_count, DEPTH);
    else passes++;
    repeat (40) begin
      tick();
      if (read !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad)
      $display("FAIL full_idle: got read=1 want read=0");
    else passes++;
    checks++;
    if (ack_count != DEPTH)
      $display("FAIL full_acks: got %0d want %0d", ack_count, DEPTH);
    else passes++;
  endtask

  task automatic test_pop_one();
    int cyc = 0;
    bit bad = 1'b0;
    pop_stream(1);
    while (ack_count < DEPTH + 1 && cyc < 100) begin
      tick();
      cyc++;
    end
    checks++;
    if (last_ack_addr !== 24'd16)
      $display("FAIL refill_addr: got %h want 000010", last_ack_addr);
    else passes++;
    repeat (40) begin
      tick();
      if (read !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || ack_count != DEPTH + 1)
      $display("FAIL one_refill: got %0d acks want %0d",
               ack_count, DEPTH + 1);
    else passes++;
  endtask

  task automatic test_wrap();
    pop_stream(40);
    checks++;
    if (wrap_seen !== 1'b1)
      $display("FAIL addr_wrap: got %b want 1", wrap_seen);
    else passes++;
  endtask

  task automatic test_underflow();
    rst = 1'b1;
    reset_model();
    tick();
    rst = 1'b0;
    pixelRead = 1'b1;
    tick();
    pixelRead = 1'b0;
    checks++;
    if (underflow !== 1'b1)
      $display("FAIL uflow_set: got %b want 1", underflow);
    else passes++;
    checks++;
    if (pixelValid !== 1'b0)
      $display("FAIL uflow_valid: got %b want 0", pixelValid);
    else passes++;
    repeat (20) tick();
    checks++;
    if (underflow !== 1'b1)
      $display("FAIL uflow_held: got %b want 1", underflow);
    else passes++;
    checks++;
    if (pixelValid !== 1'b1)
      $display("FAIL uflow_refill: got %b want 1", pixelValid);
    else passes++;
  endtask

  task automatic test_frame_start();
    int cyc = 0;
    int a0;
    while (!(read === 1'b1 && readAddress === 24'd7) && cyc < 200) begin
      tick();
      cyc++;
    end
    checks++;
    if (readAddress !== 24'd7 || read !== 1'b1)
      $display("FAIL fs_reach7: got %h want 000007", readAddress);
    else passes++;
    a0 = ack_count;
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
    cyc = 0;
    while (ack_count == a0 && cyc < 20) begin
      tick();
      cyc++;
    end
    checks++;
    if (last_ack_addr !== 24'd7)
      $display("FAIL fs_word7: got %h want 000007", last_ack_addr);
    else passes++;
    cyc = 0;
    tick();
    while (read !== 1'b1 && cyc < 30) begin
      tick();
      cyc++;
    end
    checks++;
    if (read !== 1'b1 || readAddress !== BASE)
      $display("FAIL fs_restart: got %h want %h", readAddress, BASE);
    else passes++;
    checks++;
    if (pixelValid !== 1'b0)
      $display("FAIL fs_flush: got %b want 0", pixelValid);
    else passes++;
    checks++;
    if (underflow !== 1'b0)
      $display("FAIL fs_uflow: got %b want 0", underflow);
    else passes++;
    reset_model();
    pop_stream(3);
  endtask

  task automatic test_ack_hold();
    int cyc = 0;
    int hi = 0;
    int a0;
    bit bad = 1'b0;
    @(negedge clk133_p);
    extra_hold = 3;
    a0 = ack_count;
    while (ack_count == a0 && cyc < 200) begin
      tick();
      cyc++;
    end
    tick();
    while (readAcknowledge && hi < 20) begin
      if (read !== 1'b0) bad = 1'b1;
      hi++;
      tick();
    end
    extra_hold = 0;
    checks++;
    if (bad || ack_count != a0 + 1)
      $display("FAIL hold_noreq: got %0d acks want %0d",
               ack_count - a0, 1);
    else passes++;
    cyc = 0;
    while (read !== 1'b1 && cyc < 10) begin
      tick();
      cyc++;
    end
    checks++;
    if (read !== 1'b1)
      $display("FAIL hold_resume: got %b want 1", read);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    while (read !== 1'b1 && cyc < 50) begin
      tick();
      cyc++;
    end
    #2;
    rst = 1'b1;
    reset_model();
    #1;
    checks++;
    if (read !== 1'b0)
      $display("FAIL rst_mid_read: got %b want 0", read);
    else passes++;
    checks++;
    if (readAddress !== BASE)
      $display("FAIL rst_mid_addr: got %h want %h", readAddress, BASE);
    else passes++;
    tick();
    tick();
    rst = 1'b0;
    pop_stream(2);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_pop_one();
    test_wrap();
    test_underflow();
    test_frame_start();
    test_ack_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
